// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one single-ported memory, tracking in-flight tags in order.
// Define MEM_ARB_PERF_CNT_EN to add the conflict / killed-response performance counters.
module mem_port_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic                if_gnt_o,
   output logic                if_rvalid_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   input  logic                dm_req_i,
   input  logic                dm_we_i,
   input  logic [DATA_W/8-1:0] dm_be_i,
   input  logic [ADDR_W-1:0]   dm_addr_i,
   input  logic [DATA_W-1:0]   dm_wdata_i,
   output logic                dm_gnt_o,
   output logic                dm_rvalid_o,
   output logic [DATA_W-1:0]   dm_rdata_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   input  logic                flush_i,
   output logic                err_o
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   output logic [31:0]         perf_conflict_o,
   output logic [31:0]         perf_killed_o
`endif
);

   localparam int DEPTH = MAX_OUTSTANDING;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam int BE_W  = DATA_W / 8;

   logic [DEPTH-1:0] valid_reg, valid_next;
   logic [DEPTH-1:0] src_reg, src_next;
   logic [DEPTH-1:0] killed_reg, killed_next;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [STV_W-1:0] starve_reg, starve_next;
   logic             err_reg;

   logic full, sel_if, sel_dm, accept;
   logic head_valid, head_src, head_killed, pop, stray;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Outputs are held at zero while reset is asserted, even with requests pending.
   assign full   = (count_reg == CNT_W'(DEPTH));
   assign sel_if = rstn_i & ~full & if_req_i & (~dm_req_i | (starve_reg == STV_W'(STARVE_LIMIT)));
   assign sel_dm = rstn_i & ~full & dm_req_i & ~sel_if;
   assign accept = (sel_if | sel_dm) & mem_gnt_i;

   assign mem_req_o   = sel_if | sel_dm;
   assign mem_we_o    = sel_dm & dm_we_i;
   assign mem_be_o    = sel_dm ? dm_be_i : {BE_W{sel_if}};
   assign mem_addr_o  = sel_dm ? dm_addr_i : (sel_if ? if_addr_i : '0);
   assign mem_wdata_o = sel_dm ? dm_wdata_i : '0;
   assign if_gnt_o    = sel_if & mem_gnt_i;
   assign dm_gnt_o    = sel_dm & mem_gnt_i;

   // A flush in the same cycle as a fetch response suppresses that response too.
   assign head_valid  = valid_reg[rd_ptr_reg];
   assign head_src    = src_reg[rd_ptr_reg];
   assign head_killed = killed_reg[rd_ptr_reg] | flush_i;
   assign pop         = rstn_i & mem_rvalid_i & head_valid;
   assign stray       = mem_rvalid_i & ~head_valid;

   assign if_rvalid_o = pop & ~head_src & ~head_killed;
   assign dm_rvalid_o = pop & head_src;
   assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
   assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
   assign err_o       = err_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_tag
         logic push_here, pop_here;
         assign push_here       = accept & (wr_ptr_reg == PTR_W'(gi));
         assign pop_here        = pop & (rd_ptr_reg == PTR_W'(gi));
         assign valid_next[gi]  = push_here | (valid_reg[gi] & ~pop_here);
         assign src_next[gi]    = push_here ? sel_dm : src_reg[gi];
         assign killed_next[gi] = push_here ? (sel_if & flush_i)
                                            : (killed_reg[gi] | (flush_i & valid_reg[gi] & ~src_reg[gi]));
      end
   endgenerate

   assign wr_ptr_next = accept ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
   assign rd_ptr_next = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;

   always_comb begin
      count_next = count_reg;
      if (accept && !pop) begin
         count_next = count_reg + CNT_W'(1);
      end else if (!accept && pop) begin
         count_next = count_reg - CNT_W'(1);
      end
   end

   always_comb begin
      starve_next = starve_reg;
      if (!if_req_i || if_gnt_o) begin
         starve_next = '0;
      end else if (dm_req_i && dm_gnt_o && (starve_reg != STV_W'(STARVE_LIMIT))) begin
         starve_next = starve_reg + STV_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         valid_reg  <= '0;
         src_reg    <= '0;
         killed_reg <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         starve_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         valid_reg  <= valid_next;
         src_reg    <= src_next;
         killed_reg <= killed_next;
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         starve_reg <= starve_next;
         err_reg    <= err_reg | stray;
      end
   end

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] perf_conflict_reg, perf_killed_reg;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         perf_conflict_reg <= '0;
         perf_killed_reg   <= '0;
      end else begin
         if (if_req_i && dm_req_i) begin
            perf_conflict_reg <= perf_conflict_reg + 32'd1;
         end
         if (pop && !head_src && head_killed) begin
            perf_killed_reg <= perf_killed_reg + 32'd1;
         end
      end
   end

   assign perf_conflict_o = perf_conflict_reg;
   assign perf_killed_o   = perf_killed_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a queue-based behavioural model.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MO = 2;
   localparam int SL = 4;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_gnt_o, if_rvalid_o;
   logic [DW-1:0] if_rdata_o;
   logic          dm_req_i, dm_we_i;
   logic [BW-1:0] dm_be_i;
   logic [AW-1:0] dm_addr_i;
   logic [DW-1:0] dm_wdata_i;
   logic          dm_gnt_o, dm_rvalid_o;
   logic [DW-1:0] dm_rdata_o;
   logic          mem_req_o, mem_we_o;
   logic [BW-1:0] mem_be_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_gnt_i, mem_rvalid_i;
   logic [DW-1:0] mem_rdata_i;
   logic          flush_i, err_o;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)
   ) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
      .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .flush_i(flush_i), .err_o(err_o)
   );

   int tests = 0;
   int fails = 0;

   // Model: in-flight tags as a queue, oldest first.
   typedef struct packed {
      logic src;
      logic killed;
   } tag_t;
   tag_t          mq[$];
   logic [DW-1:0] resp_q[$];
   int            m_starve;
   logic          m_err;

   int            e_win;
   logic          e_mem_req, e_mem_we, e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv;
   logic [BW-1:0] e_mem_be;
   logic [AW-1:0] e_mem_addr;
   logic [DW-1:0] e_if_rd, e_dm_rd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      resp_q.delete();
      m_starve = 0;
      m_err    = 1'b0;
   endtask

   task automatic idle_inputs();
      if_req_i = 1'b0; if_addr_i = '0;
      dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; flush_i = 1'b0;
   endtask

   task automatic predict();
      logic full;
      full  = (mq.size() >= MO);
      e_win = 0;
      if (!full) begin
         if (if_req_i && dm_req_i) e_win = (m_starve == SL) ? 1 : 2;
         else if (if_req_i)        e_win = 1;
         else if (dm_req_i)        e_win = 2;
      end
      e_mem_req  = (e_win != 0);
      e_mem_we   = (e_win == 2) ? dm_we_i : 1'b0;
      e_mem_be   = (e_win == 2) ? dm_be_i : '1;
      e_mem_addr = (e_win == 2) ? dm_addr_i : if_addr_i;
      e_if_gnt   = (e_win == 1) && mem_gnt_i;
      e_dm_gnt   = (e_win == 2) && mem_gnt_i;
      e_if_rv    = 1'b0;
      e_dm_rv    = 1'b0;
      if (mem_rvalid_i && mq.size() > 0) begin
         if (mq[0].src) e_dm_rv = 1'b1;
         else if (!mq[0].killed && !flush_i) e_if_rv = 1'b1;
      end
      e_if_rd = e_if_rv ? mem_rdata_i : '0;
      e_dm_rd = e_dm_rv ? mem_rdata_i : '0;
   endtask

   task automatic compare_all();
      chk("mem_req", mem_req_o, e_mem_req);
      if (e_win != 0) begin
         chk("mem_we", mem_we_o, e_mem_we);
         chk("mem_be", mem_be_o, e_mem_be);
         chk("mem_addr", mem_addr_o, e_mem_addr);
      end
      if (e_win == 2) chk("mem_wdata", mem_wdata_o, dm_wdata_i);
      chk("if_gnt", if_gnt_o, e_if_gnt);
      chk("dm_gnt", dm_gnt_o, e_dm_gnt);
      chk("if_rvalid", if_rvalid_o, e_if_rv);
      chk("if_rdata", if_rdata_o, e_if_rd);
      chk("dm_rvalid", dm_rvalid_o, e_dm_rv);
      chk("dm_rdata", dm_rdata_o, e_dm_rd);
      chk("err", err_o, m_err);
   endtask

   task automatic update_model();
      tag_t t;
      if (mem_rvalid_i) begin
         if (mq.size() == 0) begin
            m_err = 1'b1;
            $display("[TB] t=%0t stray response data=%h", $time, mem_rdata_i);
         end else begin
            t = mq.pop_front();
            $display("[TB] t=%0t response src=%0d killed=%0d data=%h", $time, t.src, t.killed | flush_i, mem_rdata_i);
         end
      end
      if (flush_i) begin
         for (int i = 0; i < mq.size(); i++) if (!mq[i].src) mq[i].killed = 1'b1;
      end
      if (e_win != 0 && mem_gnt_i) begin
         t.src    = (e_win == 2);
         t.killed = (e_win == 1) && flush_i;
         mq.push_back(t);
         resp_q.push_back($urandom);
         $display("[TB] t=%0t accept %s addr=%h", $time, (e_win == 2) ? "data" : "fetch", e_mem_addr);
      end
      if (if_req_i && dm_req_i && e_dm_gnt) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
      else if (e_if_gnt || !if_req_i)       m_starve = 0;
   endtask

   task automatic settle();
      @(negedge clk_i);
      predict();
      compare_all();
   endtask

   task automatic advance();
      @(posedge clk_i);
      update_model();
      #1;
   endtask

   task automatic cycle();
      settle();
      advance();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_if_gnt"}, if_gnt_o, 1'b0);
      chk({tag, "_if_rvalid"}, if_rvalid_o, 1'b0);
      chk({tag, "_if_rdata"}, if_rdata_o, '0);
      chk({tag, "_dm_gnt"}, dm_gnt_o, 1'b0);
      chk({tag, "_dm_rvalid"}, dm_rvalid_o, 1'b0);
      chk({tag, "_dm_rdata"}, dm_rdata_o, '0);
      chk({tag, "_mem_req"}, mem_req_o, 1'b0);
      chk({tag, "_mem_we"}, mem_we_o, 1'b0);
      chk({tag, "_mem_be"}, mem_be_o, '0);
      chk({tag, "_mem_addr"}, mem_addr_o, '0);
      chk({tag, "_mem_wdata"}, mem_wdata_o, '0);
      chk({tag, "_err"}, err_o, 1'b0);
   endtask

   task automatic apply_reset(input string tag);
      rstn_i = 1'b0;
      #1;
      check_zero(tag);
      model_reset();
      @(posedge clk_i);
      #2 rstn_i = 1'b1;
   endtask

   logic if_hold, dm_hold;

   initial begin
      idle_inputs();
      model_reset();
      apply_reset("rst");

      // Solo fetch with a one-cycle memory response.
      if_req_i = 1'b1; if_addr_i = 32'h100; mem_gnt_i = 1'b1;
      settle();
      chk("solo_if_gnt", if_gnt_o, 1'b1);
      chk("solo_mem_addr", mem_addr_o, 32'h100);
      advance();
      if_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
      settle();
      chk("solo_if_rvalid", if_rvalid_o, 1'b1);
      chk("solo_if_rdata", if_rdata_o, 32'hDEADBEEF);
      chk("solo_dm_rvalid", dm_rvalid_o, 1'b0);
      advance();
      idle_inputs();

      // Starvation: data wins four times, then fetch, then data again.
      if_req_i = 1'b1; if_addr_i = 32'h180;
      dm_req_i = 1'b1; dm_addr_i = 32'h400; dm_be_i = '1; mem_gnt_i = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         mem_rvalid_i = (c > 1);
         mem_rdata_i  = $urandom;
         settle();
         if (c == 5) begin
            chk($sformatf("starve_if_gnt_c%0d", c), if_gnt_o, 1'b1);
            chk($sformatf("starve_dm_gnt_c%0d", c), dm_gnt_o, 1'b0);
         end else begin
            chk($sformatf("starve_if_gnt_c%0d", c), if_gnt_o, 1'b0);
            chk($sformatf("starve_dm_gnt_c%0d", c), dm_gnt_o, 1'b1);
         end
         advance();
      end
      idle_inputs();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
      settle();
      chk("starve_drain_dm_rvalid", dm_rvalid_o, 1'b1);
      advance();
      idle_inputs();

      // Full condition with responses withheld.
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = '1; dm_addr_i = 32'h500; mem_gnt_i = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         mem_rvalid_i = (c == 4);
         mem_rdata_i  = 32'h5000 + c;
         settle();
         case (c)
            1, 2: chk($sformatf("full_dm_gnt_c%0d", c), dm_gnt_o, 1'b1);
            3: begin
               chk("full_mem_req_c3", mem_req_o, 1'b0);
               chk("full_dm_gnt_c3", dm_gnt_o, 1'b0);
            end
            4: begin
               chk("full_mem_req_c4", mem_req_o, 1'b0);
               chk("full_dm_gnt_c4", dm_gnt_o, 1'b0);
               chk("full_dm_rvalid_c4", dm_rvalid_o, 1'b1);
            end
            default: chk("full_dm_gnt_c5", dm_gnt_o, 1'b1);
         endcase
         advance();
      end
      idle_inputs();
      mem_rvalid_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         mem_rdata_i = 32'h6000 + c;
         settle();
         chk($sformatf("full_drain_dm_rvalid_%0d", c), dm_rvalid_o, 1'b1);
         advance();
      end
      idle_inputs();

      // Flush kills two in-flight fetches; a later fetch returns normally.
      if_req_i = 1'b1; mem_gnt_i = 1'b1; if_addr_i = 32'h200;
      settle(); chk("flush_if_gnt_0", if_gnt_o, 1'b1); advance();
      if_addr_i = 32'h204;
      settle(); chk("flush_if_gnt_1", if_gnt_o, 1'b1); advance();
      if_req_i = 1'b0; flush_i = 1'b1;
      cycle();
      flush_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11;
      settle(); chk("flush_if_rvalid_11", if_rvalid_o, 1'b0); advance();
      mem_rdata_i = 32'h22;
      settle(); chk("flush_if_rvalid_22", if_rvalid_o, 1'b0); advance();
      mem_rvalid_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h300;
      settle(); chk("post_flush_if_gnt", if_gnt_o, 1'b1); advance();
      if_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h33;
      settle();
      chk("post_flush_if_rvalid", if_rvalid_o, 1'b1);
      chk("post_flush_if_rdata", if_rdata_o, 32'h33);
      advance();
      idle_inputs();

      // Interleaved fetch / store / load with in-order responses A, B, C.
      mem_gnt_i = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h600;
      settle(); chk("ilv_if_gnt", if_gnt_o, 1'b1); advance();
      if_req_i = 1'b0;
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'b0011; dm_addr_i = 32'h700; dm_wdata_i = 32'hCAFE0001;
      settle();
      chk("ilv_st_gnt", dm_gnt_o, 1'b1);
      chk("ilv_st_we", mem_we_o, 1'b1);
      chk("ilv_st_be", mem_be_o, 4'b0011);
      chk("ilv_st_wdata", mem_wdata_o, 32'hCAFE0001);
      advance();
      dm_we_i = 1'b0; dm_be_i = 4'b1111; dm_addr_i = 32'h704; dm_wdata_i = '0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA0001;
      settle();
      chk("ilv_ld_blocked", dm_gnt_o, 1'b0);
      chk("ilv_A_if_rvalid", if_rvalid_o, 1'b1);
      chk("ilv_A_if_rdata", if_rdata_o, 32'hAAAA0001);
      chk("ilv_A_dm_rvalid", dm_rvalid_o, 1'b0);
      advance();
      mem_rdata_i = 32'hBBBB0002;
      settle();
      chk("ilv_ld_gnt", dm_gnt_o, 1'b1);
      chk("ilv_B_dm_rvalid", dm_rvalid_o, 1'b1);
      chk("ilv_B_if_rvalid", if_rvalid_o, 1'b0);
      advance();
      dm_req_i = 1'b0; mem_rdata_i = 32'hCCCC0003;
      settle();
      chk("ilv_C_dm_rvalid", dm_rvalid_o, 1'b1);
      chk("ilv_C_dm_rdata", dm_rdata_o, 32'hCCCC0003);
      advance();
      idle_inputs();

      // Stray response sets a sticky error.
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
      settle();
      chk("stray_if_rvalid", if_rvalid_o, 1'b0);
      chk("stray_dm_rvalid", dm_rvalid_o, 1'b0);
      advance();
      idle_inputs();
      settle(); chk("stray_err_set", err_o, 1'b1); advance();
      settle(); chk("stray_err_held", err_o, 1'b1); advance();

      // Asynchronous reset mid-burst, then the orphaned response is a stray.
      if_req_i = 1'b1; if_addr_i = 32'h800; mem_gnt_i = 1'b1;
      cycle();
      dm_req_i = 1'b1; dm_addr_i = 32'h900; dm_be_i = '1; mem_rvalid_i = 1'b1;
      #3;
      apply_reset("async_rst");
      idle_inputs();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
      settle(); chk("orphan_if_rvalid", if_rvalid_o, 1'b0); advance();
      idle_inputs();
      settle(); chk("orphan_err", err_o, 1'b1); advance();

      // Randomized traffic with held requests, flushes and variable memory latency.
      apply_reset("rand_rst");
      if_hold = 1'b0;
      dm_hold = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!if_hold) begin
            if_req_i  = ($urandom % 3) != 0;
            if_addr_i = $urandom & 32'hFFFF_FFFC;
         end
         if (!dm_hold) begin
            dm_req_i   = ($urandom % 2) != 0;
            dm_we_i    = $urandom % 2;
            dm_be_i    = $urandom;
            dm_addr_i  = $urandom & 32'hFFFF_FFFC;
            dm_wdata_i = $urandom;
         end
         flush_i   = ($urandom % 8) == 0;
         mem_gnt_i = ($urandom % 4) != 0;
         if (resp_q.size() > 0 && ($urandom % 2) != 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = resp_q.pop_front();
         end else begin
            mem_rvalid_i = (resp_q.size() == 0) && (($urandom % 64) == 0);
            mem_rdata_i  = $urandom;
         end
         cycle();
         if_hold = if_req_i && !e_if_gnt;
         dm_hold = dm_req_i && !e_dm_gnt;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the mem stage (data loads/stores) of the 5-stage in-order core.
- Arbitrates each cycle, tracks in-flight transactions in an in-order tag FIFO, and routes each response back to its originator.
- Discards in-flight fetch responses on a branch redirect.
- Sits between fetch/mem and the memory model; its grant outputs feed the pipeline stall logic.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_OUTSTANDING, 2, max accepted-but-unanswered transactions; power of two, at least 1
- STARVE_LIMIT, 4, consecutive fetch-lost arbitration cycles before fetch is forced to win; at least 1

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch read request; held with its address until granted
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  DATA_W  fetch read data
- dm_req_i  in  1  data request; held with its fields until granted
- dm_we_i  in  1  1 = store
- dm_be_i  in  DATA_W/8  byte enables
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_gnt_o  out  1  data request accepted
- dm_rvalid_o  out  1  data response valid; stores also get one
- dm_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  request to memory
- mem_we_o  out  1  write enable
- mem_be_o  out  DATA_W/8  byte enables
- mem_addr_o  out  ADDR_W  address
- mem_wdata_o  out  DATA_W  write data
- mem_gnt_i  in  1  memory accepts the request this cycle
- mem_rvalid_i  in  1  memory response, strictly in request order, at least 1 cycle after accept
- mem_rdata_i  in  DATA_W  response data
- flush_i  in  1  branch redirect; kill outstanding and same-cycle fetch transactions
- err_o  out  1  sticky: response arrived with the tag FIFO empty

Behaviour:
- Reset: all outputs 0; tag FIFO empty; starvation counter 0; err_o 0. Reset mid-transaction drops all in-flight state, and later stray responses are treated as unexpected.
- Selection is combinational. If FIFO count == MAX_OUTSTANDING, mem_req_o = 0 and no grant.
- Otherwise, data wins when both request, unless the starvation counter == STARVE_LIMIT, in which case fetch wins. A lone requester always wins.
- mem_* fields are muxed from the winner; fetch drives mem_we_o = 0 and mem_be_o = all ones. mem_req_o = winner exists.
- if_gnt_o / dm_gnt_o = winner selected AND mem_gnt_i. Grant is in the same cycle, with zero added latency.
- A fetch request in a cycle with flush_i = 1 is still issued if it wins, but its tag is pushed already killed.
- Starvation counter:
  - increments (saturating at STARVE_LIMIT) when if_req_i and dm_req_i are both high and data is granted;
  - clears when fetch is granted or if_req_i = 0;
  - holds otherwise.
- Tag FIFO, depth MAX_OUTSTANDING, one entry per accepted transaction: {src (0 = fetch, 1 = data), killed}.
  - Push on accept (mem_req_o & mem_gnt_i); pop on mem_rvalid_i.
  - Push and pop in the same cycle: count unchanged; pointers both advance, wrapping modulo depth.
  - Accept is blocked only by the full condition evaluated before the same-cycle pop. A simultaneous pop does not free a slot in that cycle.
- flush_i: sets killed on every valid FIFO entry whose src = fetch, effective for responses from the next cycle onward.
  - A response popping in the flush cycle is also suppressed if it is a fetch response.
  - Data entries are unaffected.
- Response routing is combinational from mem_rvalid_i and the FIFO head:
  - head src = fetch and not killed: if_rvalid_o = 1, if_rdata_o = mem_rdata_i;
  - head src = data: dm_rvalid_o = 1, dm_rdata_o = mem_rdata_i;
  - killed entry: popped silently.
  - rdata outputs are 0 when the matching rvalid is 0.
- mem_rvalid_i with the FIFO empty: ignored (no pop, no rvalid), and err_o set until reset.

Optional Feature:
- Macro MEM_ARB_PERF_CNT_EN adds two outputs, perf_conflict_o (32) and perf_killed_o (32), both reset to 0 and wrapping.
  - perf_conflict_o counts cycles with if_req_i & dm_req_i.
  - perf_killed_o counts suppressed fetch responses.
- Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Solo fetch: if_req_i = 1, addr 0x100; memory grants immediately and responds after 1 cycle with 0xDEADBEEF -> if_gnt_o in the request cycle; if_rvalid_o = 1, if_rdata_o = 0xDEADBEEF one cycle later; dm_rvalid_o stays 0.
- Conflict priority and starvation (STARVE_LIMIT = 4, mem_gnt_i = 1, FIFO kept draining):
  - both requests held continuously -> data granted for 4 cycles;
  - fetch granted on the 5th;
  - data again on the 6th.
- Full condition (MAX_OUTSTANDING = 2, responses withheld): three data loads -> first two granted; the third sees mem_req_o = 0 until the first response arrives; no grant in the response cycle itself; grant the cycle after.
- Flush: two fetches in flight, flush_i pulsed, responses 0x11 and 0x22 then arrive -> if_rvalid_o never asserts and the FIFO ends empty. A subsequent unflushed fetch returns normally.
- Interleaved order: fetch, then store, then load accepted; responses A, B, C -> if_rvalid with A, dm_rvalid for B, dm_rvalid with C, in that order.
- Stray response: mem_rvalid_i with the FIFO empty -> no rvalid, err_o = 1 and held. Async reset mid-burst -> all outputs 0 immediately, err_o cleared.
